// File: rtl/adder_arbiter.sv
// adder_arbiter: two valid/ready requesters share one ripple-carry adder.
// Round-robin grant in IDLE, operands registered, one full cycle for the
// ripple chain to settle, then the N+1 bit sum is held for the owner.

// Plain ripple-carry adder; the carry chain is the long combinational path.
module ripple #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N:0]   sum
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum[N] = carry[N];

endmodule

module adder_arbiter #(
  parameter int N = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Req0Valid,
  output logic         Req0Ready,
  input  logic [N-1:0] Req0A,
  input  logic [N-1:0] Req0B,
  input  logic         Req1Valid,
  output logic         Req1Ready,
  input  logic [N-1:0] Req1A,
  input  logic [N-1:0] Req1B,
  output logic         Resp0Valid,
  input  logic         Resp0Ready,
  output logic [N:0]   Resp0Sum,
  output logic         Resp1Valid,
  input  logic         Resp1Ready,
  output logic [N:0]   Resp1Sum,
  output logic         Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         owner;
  logic         last_grant;
  logic [N:0]   result;
  logic [N:0]   add_sum;

  logic grant;
  logic idle_ok;
  logic accept;
  logic resp_done;

  // The adder sees only registered operands, so its path is register to register.
  ripple #(.N(N)) u_ripple (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (add_sum)
  );

  // Round-robin choice: on contention favour whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    if (Req0Valid && Req1Valid) begin
      grant = ~last_grant;
    end else if (Req1Valid) begin
      grant = 1'b1;
    end
  end

  // Ready is withheld while reset is asserted so no request is taken then.
  assign idle_ok   = (state == IDLE) && !Rst;
  assign Req0Ready = idle_ok && !grant && Req0Valid;
  assign Req1Ready = idle_ok &&  grant && Req1Valid;
  assign accept    = Req0Ready || Req1Ready;

  assign Resp0Valid = (state == RESP) && !owner;
  assign Resp1Valid = (state == RESP) &&  owner;
  assign Resp0Sum   = result;
  assign Resp1Sum   = result;
  assign Busy       = (state != IDLE);

  assign resp_done = (Resp0Valid && Resp0Ready) || (Resp1Valid && Resp1Ready);

  // State register; reset drops any in-flight operation immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: ADD always lasts one cycle, RESP waits for the owner's handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ADD;
        end
      end
      ADD: begin
        state_next = RESP;
      end
      RESP: begin
        if (resp_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on accept and sum capture at the end of the ADD cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_a       <= '0;
      op_b       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result     <= '0;
    end else begin
      if (accept) begin
        op_a       <= grant ? Req1A : Req0A;
        op_b       <= grant ? Req1B : Req0B;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == ADD) begin
        result <= add_sum;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level model of the arbiter.
module tb_adder_arbiter;

  localparam int N = 16;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Req0Valid = 1'b0;
  logic [N-1:0] Req0A = '0;
  logic [N-1:0] Req0B = '0;
  logic         Req1Valid = 1'b0;
  logic [N-1:0] Req1A = '0;
  logic [N-1:0] Req1B = '0;
  logic         Resp0Ready = 1'b0;
  logic         Resp1Ready = 1'b0;
  logic         Req0Ready;
  logic         Req1Ready;
  logic         Resp0Valid;
  logic         Resp1Valid;
  logic [N:0]   Resp0Sum;
  logic [N:0]   Resp1Sum;
  logic         Busy;

  adder_arbiter #(.N(N)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Req0Valid  (Req0Valid),
    .Req0Ready  (Req0Ready),
    .Req0A      (Req0A),
    .Req0B      (Req0B),
    .Req1Valid  (Req1Valid),
    .Req1Ready  (Req1Ready),
    .Req1A      (Req1A),
    .Req1B      (Req1B),
    .Resp0Valid (Resp0Valid),
    .Resp0Ready (Resp0Ready),
    .Resp0Sum   (Resp0Sum),
    .Resp1Valid (Resp1Valid),
    .Resp1Ready (Resp1Ready),
    .Resp1Sum   (Resp1Sum),
    .Busy       (Busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction model: an outstanding job plus a FIFO of (owner, sum).
  bit          pend       = 1'b0;
  int          acc_cyc    = 0;
  int          cyc        = 0;
  bit          last_grant = 1'b1;
  bit          own_q[$];
  int unsigned sum_q[$];
  int          resp_count = 0;
  int          wait0      = 0;
  int          wait1      = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare one cycle, step the clock, then update the model and drivers.
  task automatic runCycle();
    bit g;
    bit e_r0;
    bit e_r1;
    bit e_v0;
    bit e_v1;
    bit hs;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    g    = 1'b0;
    #1;
    if (!pend) begin
      if (Req0Valid && Req1Valid) g = ~last_grant;
      else                        g = Req1Valid;
      e_r0 = Req0Valid && !g;
      e_r1 = Req1Valid && g;
    end else if (cyc >= acc_cyc + 2 && own_q.size() > 0) begin
      e_v0 = !own_q[0];
      e_v1 = own_q[0];
    end
    checkOutput("req0_ready", Req0Ready, e_r0);
    checkOutput("req1_ready", Req1Ready, e_r1);
    checkOutput("one_ready", Req0Ready && Req1Ready, 0);
    checkOutput("resp0_valid", Resp0Valid, e_v0);
    checkOutput("resp1_valid", Resp1Valid, e_v1);
    checkOutput("busy", Busy, pend);
    if (e_v0) checkOutput("resp0_sum", Resp0Sum, sum_q[0]);
    if (e_v1) checkOutput("resp1_sum", Resp1Sum, sum_q[0]);
    hs = (e_v0 && Resp0Ready) || (e_v1 && Resp1Ready);
    @(posedge Clk);
    #1;
    if (e_r0 || e_r1) begin
      if (e_r0) begin
        checkOutput("starve0", wait0 <= 1, 1);
        wait0 = 0;
        if (Req1Valid) wait1++;
        sum_q.push_back(32'(Req0A) + 32'(Req0B));
        Req0Valid = 1'b0;
      end else begin
        checkOutput("starve1", wait1 <= 1, 1);
        wait1 = 0;
        if (Req0Valid) wait0++;
        sum_q.push_back(32'(Req1A) + 32'(Req1B));
        Req1Valid = 1'b0;
      end
      own_q.push_back(e_r1);
      last_grant = e_r1;
      pend       = 1'b1;
      acc_cyc    = cyc;
    end
    if (hs) begin
      void'(own_q.pop_front());
      void'(sum_q.pop_front());
      pend = 1'b0;
      resp_count++;
    end
    cyc++;
  endtask

  // Assert reset asynchronously, check every output is zero, release next cycle.
  task automatic doReset(input bit hold_valid);
    Rst       = 1'b1;
    Req0Valid = hold_valid;
    Req1Valid = hold_valid;
    #1;
    checkOutput("rst_req0_ready", Req0Ready, 0);
    checkOutput("rst_req1_ready", Req1Ready, 0);
    checkOutput("rst_resp0_valid", Resp0Valid, 0);
    checkOutput("rst_resp1_valid", Resp1Valid, 0);
    checkOutput("rst_resp0_sum", Resp0Sum, 0);
    checkOutput("rst_resp1_sum", Resp1Sum, 0);
    checkOutput("rst_busy", Busy, 0);
    @(posedge Clk);
    #1;
    Req0Valid  = 1'b0;
    Req1Valid  = 1'b0;
    Rst        = 1'b0;
    pend       = 1'b0;
    own_q.delete();
    sum_q.delete();
    last_grant = 1'b1;
    wait0      = 0;
    wait1      = 0;
  endtask

  // Random requesters that hold until accepted, and random response stalls.
  task automatic applyStimulus();
    if (!Req0Valid && $urandom_range(0, 1) == 1) begin
      Req0Valid = 1'b1;
      Req0A     = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
      Req0B     = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
    end
    if (!Req1Valid && $urandom_range(0, 1) == 1) begin
      Req1Valid = 1'b1;
      Req1A     = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
      Req1B     = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
    end
    Resp0Ready = ($urandom_range(0, 3) != 0);
    Resp1Ready = ($urandom_range(0, 3) != 0);
  endtask

  // Directed scenarios followed by the randomized run.
  initial begin
    int target;
    int guard;

    doReset(1'b1);

    // Single request with full carry-out.
    Req0Valid = 1'b1; Req0A = 16'hFFFF; Req0B = 16'h0001; Resp0Ready = 1'b1;
    repeat (4) runCycle();
    checkOutput("single_count", resp_count, 1);

    // Contention straight after reset: requester 0 first, then alternation.
    doReset(1'b0);
    Resp0Ready = 1'b1; Resp1Ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!Req0Valid) begin Req0Valid = 1'b1; Req0A = 16'd5;    Req0B = 16'd7;    end
      if (!Req1Valid) begin Req1Valid = 1'b1; Req1A = 16'h8000; Req1B = 16'h8000; end
      runCycle();
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    repeat (4) runCycle();

    // Backpressure on response 1.
    Req1Valid = 1'b1; Req1A = 16'h1234; Req1B = 16'hFEDC; Resp1Ready = 1'b0;
    repeat (8) runCycle();
    Resp1Ready = 1'b1;
    repeat (3) runCycle();

    // Reset during ADD drops the pending 3+4.
    Req0Valid = 1'b1; Req0A = 16'd3; Req0B = 16'd4; Resp0Ready = 1'b1;
    runCycle();
    doReset(1'b0);
    repeat (4) runCycle();
    Req0Valid = 1'b1; Req0A = 16'd1; Req0B = 16'd1;
    repeat (4) runCycle();

    // Randomized back-to-back traffic.
    target = resp_count + 1000;
    guard  = 0;
    while (resp_count < target && guard < 20000) begin
      applyStimulus();
      runCycle();
      guard++;
    end
    checkOutput("random_ops_done", resp_count >= target, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares a single `ripple` N-bit adder instance between two independent requesters using valid/ready handshakes and round-robin arbitration. It registers the granted operands, gives the ripple chain one full clock cycle to settle, then captures the (N+1)-bit sum and returns it on the response channel of the requester that issued it. It sits between client logic and the adder datapath so that only one ripple instance is needed per pair of clients.

## Interface
Parameters:
- N, 16, operand width; the internal `ripple` is instantiated with this N.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- Req0Valid  input  1  requester 0 has an operand pair.
- Req0Ready  output  1  requester 0 pair accepted this cycle.
- Req0A, Req0B  input  N  requester 0 operands.
- Req1Valid, Req1Ready, Req1A, Req1B: same as requester 0, for requester 1.
- Resp0Valid  output  1  sum for requester 0 available.
- Resp0Ready  input  1  requester 0 consumes the sum.
- Resp0Sum  output  N+1  result for requester 0, carry in MSB.
- Resp1Valid, Resp1Ready, Resp1Sum: same as response 0, for requester 1.
- Busy  output  1  high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE (reset state).
  - ADD: registered operands drive the ripple instance.
  - RESP: sum registered, waiting for consumer.
- Registers:
  - OpA, OpB (N bits).
  - Owner (1 bit).
  - Result (N+1 bits).
  - LastGrant (1 bit, reset 1, so requester 0 wins the first contention).
- Grant, combinational, only in IDLE:
  - Only one Valid high: that requester.
  - Both high: the requester not equal to LastGrant.
  - ReqXReady = (state==IDLE) && grant==X && ReqXValid. At most one Ready is high per cycle.
  - Ready is low in ADD and RESP.
- Accept (ReqXValid && ReqXReady):
  - Latch OpA/OpB from requester X.
  - Owner <= X; LastGrant <= X.
  - Go to ADD.
- ADD: Result <= ripple Sum of OpA + OpB, carry-in 0, width N+1, no truncation. Go to RESP. Always exactly one cycle.
- RESP:
  - RespXValid = 1 only for X == Owner; RespXSum = Result.
  - The other RespValid is 0. Its Sum also shows Result, but it is don't-care and is not to be checked.
  - On RespXValid && RespXReady, go to IDLE.
  - While Ready is low, Result and Valid hold stable.
- Requesters must hold Valid and operands stable until Ready.
- Arbitration only switches in IDLE. A Valid that rises during ADD or RESP waits for the next IDLE.
- Arithmetic is unsigned; max sum 2^(N+1)-2 fits N+1 bits.
- RespXReady is ignored when RespXValid is low.

## Timing
- Reset values:
  - state IDLE; Busy 0.
  - Req0Ready, Req1Ready 0 (no Valid is qualified during reset).
  - Resp0Valid, Resp1Valid 0; Resp0Sum, Resp1Sum 0.
  - OpA, OpB, Result 0; Owner 0; LastGrant 1.
- Reset asserted mid-operation (ADD or RESP): FSM returns to IDLE asynchronously and the pending result is dropped. No response is issued for it after reset release.
- Latency: accept edge at cycle t, ADD during t+1, RespValid high from cycle t+2.
- Response handshake at cycle r: back to IDLE at r+1. Earliest next accept is at r+1.
- Minimum interval between accepts is 3 cycles; a stalled response extends it.
- Busy: 1 from the cycle after accept through the response-handshake cycle.
- The ripple path must close timing within one Clk period. Its inputs come only from OpA/OpB registers and its output goes only to Result.

## Test plan
- Single request, N=16: Req0 A=0xFFFF, B=0x0001 at cycle t, Resp0Ready=1.
  - Required: Resp0Valid at t+2 with Resp0Sum=0x10000.
  - Required: Resp1Valid stays 0; back to IDLE at t+3.
- Contention after reset: both Valid, Req0 5+7, Req1 0x8000+0x8000, Resp ready.
  - Required: Req0 granted first; Resp0Sum=0x0000C.
  - Required: Req1 accepted at the next IDLE; Resp1Sum=0x10000.
  - Alternation 0,1,0,1 continues while both stay valid.
- Backpressure: Resp1Ready held 0 for 5 cycles after Resp1Valid rises.
  - Required: Resp1Sum stable; both Ready low; Busy high.
  - Required: one cycle after Resp1Ready=1 and the handshake, Busy=0.
- Reset in ADD: assert Rst during ADD of 3+4.
  - Required: all outputs zero immediately.
  - Required: no RespValid after release; next request 1+1 yields 0x00002 normally.
- Randomized back-to-back traffic, both requesters, random stalls, 1000 ops.
  - Required: every sum equals A+B, returned to the correct requester, in acceptance order.
  - Required: never two Ready in one cycle.
  - Required: no requester starves beyond one other grant.
